// File: rtl/droop_detector.sv
// Supply-droop detector: moving average of ring-oscillator monitor codes,
// trip/clear hysteresis with persistence counting, a hard-trip fast path on
// the raw code, a minimum brake hold time and a saturating brake-event count.
module droop_detector #(
    parameter int W                = 10,
    parameter int AVG_LOG2         = 2,
    parameter int TRIP_THRESH      = 400,
    parameter int CLEAR_THRESH     = 420,
    parameter int HARD_THRESH      = 360,
    parameter int TRIP_CYCLES      = 3,
    parameter int CLEAR_CYCLES     = 8,
    parameter int MIN_BRAKE_CYCLES = 16,
    parameter int EVT_W            = 16
) (
    input  logic             refclk,
    input  logic             reset,
    input  logic             en,
    input  logic [W-1:0]     mon_code,
    input  logic             mon_valid,
    output logic             brake,
    output logic [1:0]       droop_state,
    output logic [W-1:0]     avg_code,
    output logic [EVT_W-1:0] event_count
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = W + AVG_LOG2;
    // Counter widths always leave room for the terminal value plus one.
    localparam int CW = $clog2(TRIP_CYCLES + 2);
    localparam int LW = $clog2(CLEAR_CYCLES + 2);
    localparam int HW = $clog2(MIN_BRAKE_CYCLES + 2);

    localparam logic [W-1:0]  CODE_MAX = '1;
    localparam logic [SW-1:0] SUM_INIT = SW'(CODE_MAX) << AVG_LOG2;
    localparam logic [W-1:0]  TRIP_T   = W'(TRIP_THRESH);
    localparam logic [W-1:0]  CLEAR_T  = W'(CLEAR_THRESH);
    localparam logic [W-1:0]  HARD_T   = W'(HARD_THRESH);
    localparam logic [CW-1:0] TRIP_N   = CW'(TRIP_CYCLES);
    localparam logic [LW-1:0] CLEAR_N  = LW'(CLEAR_CYCLES);
    localparam logic [HW-1:0] MIN_HI   = HW'(MIN_BRAKE_CYCLES);

    typedef enum logic [1:0] {
        MONITOR  = 2'd0,
        TRIPPING = 2'd1,
        BRAKE    = 2'd2,
        CLEARING = 2'd3
    } state_t;

    // History: entry 0 is the newest sample, entry N-1 the oldest.
    logic [W-1:0]  hist_reg  [N];
    logic [W-1:0]  hist_next [N];
    logic [SW-1:0] sum_reg, sum_next;
    logic [W-1:0]  avg_reg;
    logic          upd_reg;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [LW-1:0]   clr_reg, clr_next;
    logic [HW-1:0]   hi_reg, hi_next, hi_inc;
    logic            brake_reg, brake_next;
    logic [EVT_W-1:0] evt_reg;
    logic            evt_inc;
    logic            hard_trip, below_trip, at_clear;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign hist_next[gi] = mon_code;
            end else begin : g_tail
                assign hist_next[gi] = hist_reg[gi-1];
            end
        end
    endgenerate

    // Running sum never exceeds N*(2^W-1), so modular add/subtract is exact.
    assign sum_next = sum_reg + SW'(mon_code) - SW'(hist_reg[N-1]);

    // Sample history, running sum and averaged code; upd flags a fresh average.
    always_ff @(posedge refclk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) hist_reg[i] <= CODE_MAX;
            sum_reg <= SUM_INIT;
            avg_reg <= CODE_MAX;
            upd_reg <= 1'b0;
        end else begin
            upd_reg <= mon_valid;
            if (mon_valid) begin
                for (int i = 0; i < N; i++) hist_reg[i] <= hist_next[i];
                sum_reg <= sum_next;
                avg_reg <= sum_next[SW-1:AVG_LOG2];
            end
        end
    end

    assign hard_trip  = en && mon_valid && (mon_code < HARD_T);
    assign below_trip = upd_reg && (avg_reg < TRIP_T);
    assign at_clear   = upd_reg && (avg_reg >= CLEAR_T);
    assign hi_inc     = (hi_reg >= MIN_HI) ? hi_reg : hi_reg + 1'b1;

    // Next-state logic: disable, then hard trip, then averaged decisions.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        clr_next   = clr_reg;
        hi_next    = hi_reg;
        evt_inc    = 1'b0;
        if (!en) begin
            state_next = MONITOR;
            cnt_next   = '0;
            clr_next   = '0;
            hi_next    = '0;
        end else if (hard_trip) begin
            state_next = BRAKE;
            cnt_next   = '0;
            clr_next   = '0;
            hi_next    = HW'(1);
            evt_inc    = (state_reg == MONITOR) || (state_reg == TRIPPING);
        end else begin
            case (state_reg)
                MONITOR: begin
                    if (below_trip) begin
                        if (TRIP_CYCLES == 1) begin
                            state_next = BRAKE;
                            cnt_next   = '0;
                            hi_next    = HW'(1);
                            evt_inc    = 1'b1;
                        end else begin
                            state_next = TRIPPING;
                            cnt_next   = CW'(1);
                        end
                    end
                end
                TRIPPING: begin
                    if (below_trip) begin
                        if (cnt_reg + 1'b1 == TRIP_N) begin
                            state_next = BRAKE;
                            cnt_next   = '0;
                            hi_next    = HW'(1);
                            evt_inc    = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end else if (upd_reg) begin
                        state_next = MONITOR;
                        cnt_next   = '0;
                    end
                end
                BRAKE: begin
                    hi_next = hi_inc;
                    if (at_clear && (hi_reg >= MIN_HI)) begin
                        if (CLEAR_CYCLES == 1) begin
                            state_next = MONITOR;
                            clr_next   = '0;
                            hi_next    = '0;
                        end else begin
                            state_next = CLEARING;
                            clr_next   = LW'(1);
                        end
                    end
                end
                default: begin // CLEARING
                    hi_next = hi_inc;
                    if (at_clear) begin
                        if (clr_reg + 1'b1 == CLEAR_N) begin
                            state_next = MONITOR;
                            clr_next   = '0;
                            hi_next    = '0;
                        end else begin
                            clr_next = clr_reg + 1'b1;
                        end
                    end else if (upd_reg) begin
                        // Hold time keeps accumulating across a failed release.
                        state_next = BRAKE;
                        clr_next   = '0;
                    end
                end
            endcase
        end
        brake_next = (state_next == BRAKE) || (state_next == CLEARING);
    end

    // State, counters, registered brake and saturating event count.
    always_ff @(posedge refclk) begin
        if (reset) begin
            state_reg <= MONITOR;
            cnt_reg   <= '0;
            clr_reg   <= '0;
            hi_reg    <= '0;
            brake_reg <= 1'b0;
            evt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            clr_reg   <= clr_next;
            hi_reg    <= hi_next;
            brake_reg <= brake_next;
            if (evt_inc && (evt_reg != '1)) evt_reg <= evt_reg + 1'b1;
        end
    end

    assign brake       = brake_reg;
    assign droop_state = state_reg;
    assign avg_code    = avg_reg;
    assign event_count = evt_reg;

endmodule
